door_sequencer: RTL
===================

// Module: door_sequencer
// PURPOSE
// Upstream control stage of the door FSM. It combines the state register and the period timer.
// Produces state_reg, t, sec_t and btn, which feed the output stage that drives door LEDs,
// the panic LED and the HEX displays.
// Sequences one door through IDLE->OPEN->WAIT->CLOSE->IDLE on a request.
// Panic input overrides every state.
// PARAMETERS
// T            8    last value of t; one period = T+1 clk cycles; T%4==0, T>=4
// TIMER_W      4    width of t; T < 2**TIMER_W
// STATE_W      3    width of state_reg and sec_t
// OPEN_STEPS   4    periods in OPEN and in CLOSE (one LED step per period)
// WAIT_PERIODS 2    periods the door stays open in WAIT
// PORTS
// clk        in   1        system clock (PLL output)
// rst        in   1        synchronous, active-high reset
// req_0      in   1        open request, door 0; synchronised level, sampled every clk
// req_1      in   1        open request, door 1; synchronised level
// panic_sw   in   1        panic switch, level; high = panic
// state_reg  out  STATE_W  IDLE=0 OPEN=1 WAIT=2 CLOSE=3 PANIC=4 (project state macros)
// t          out  TIMER_W  cycle counter within current period, 0..T
// sec_t      out  STATE_W  completed-period counter within current state
// btn        out  1        selected door: 0 = door 0, 1 = door 1
// BEHAVIOUR
// - Interface: one clock clk; reset rst is synchronous and active-high.
// - Reset: state_reg=IDLE, t=0, sec_t=0, btn=0. Takes effect at the next clk edge in any state.
// - All outputs are registered. A decision on cycle n is visible on cycle n+1.
// - Period end (pe) is the condition t==T.
// - Timer in IDLE: t and sec_t are held at 0.
// - Timer in other states, at pe:
//   - t wraps to 0.
//   - sec_t increments. In PANIC it saturates at 2**STATE_W-1.
// - Timer in other states, not at pe: t increments.
// - Any state change loads t=0 and sec_t=0 on the same edge.
// - Priority, highest first: rst, panic_sw, state transitions.
// - panic_sw=1 in any non-PANIC state: next state PANIC.
// - IDLE:
//   - req_0=1: go to OPEN with btn=0.
//   - else req_1=1: go to OPEN with btn=1.
//   - If both are high, door 0 wins.
// - OPEN: at pe with sec_t==OPEN_STEPS-1, go to WAIT.
// - WAIT:
//   - At pe with sec_t==WAIT_PERIODS-1, go to CLOSE.
//   - A request for the selected door (req_btn) restarts the wait: t=0, sec_t=0, state unchanged.
//   - The restart wins over expiry on the same cycle.
//   - Requests for the other door are ignored.
// - CLOSE: at pe with sec_t==OPEN_STEPS-1, go to IDLE. Requests are ignored; no re-open.
// - PANIC:
//   - Stays in PANIC while panic_sw=1.
//   - Exits to IDLE at the first pe with panic_sw=0. This guarantees the four quarter-period
//     close steps of a full period have completed.
//   - Going to IDLE clears btn to 0.
// - btn changes only on IDLE->OPEN, PANIC->IDLE and reset. Otherwise it is stable.
// - Illegal state code (5..7): next state IDLE, t=0, sec_t=0, btn unchanged.
// - Requests arriving while not in IDLE are not queued.
// TESTING (defaults: T=8, period = 9 cycles)
// 1. rst held 2 cycles -> state_reg=0, t=0, sec_t=0, btn=0. All outputs stay 0 with no inputs.
// 2. 1-cycle pulse on req_0 in IDLE:
//    - next cycle: OPEN, btn=0, t=0.
//    - 36 cycles later: WAIT; 18 later: CLOSE; 36 later: IDLE.
//    - t sweeps 0..8 every period throughout.
// 3. req_0 and req_1 high together in IDLE -> OPEN with btn=0. req_1 then ignored to IDLE.
// 4. btn=1 in WAIT at sec_t=1, t=4; pulse req_1:
//    - next cycle: t=0, sec_t=0, still WAIT; CLOSE only 18 cycles later.
//    - req_0 pulse instead -> no effect.
// 5. panic_sw up in OPEN at t=5:
//    - next cycle: PANIC, t=0, sec_t=0.
//    - drop panic_sw at sec_t=1, t=3 -> IDLE the cycle after t==8; btn=0.
// 6. rst asserted in CLOSE at t=6 -> next cycle IDLE, t=0, sec_t=0, btn=0.
//    Force state 6 via the bench -> IDLE next cycle.

Source files
------------

// File: rtl/door_sequencer_if.sv
// Request/status bundle between the door sequencer and its surroundings.
// The master drives requests and panic; the slave (sequencer) reports state and timers.
interface door_sequencer_if #(
  parameter int TIMER_W = 4,
  parameter int STATE_W = 3
);
  logic               req_0;
  logic               req_1;
  logic               panic_sw;
  logic [STATE_W-1:0] state_reg;
  logic [TIMER_W-1:0] t;
  logic [STATE_W-1:0] sec_t;
  logic               btn;

  modport master (output req_0, req_1, panic_sw,
                  input  state_reg, t, sec_t, btn);
  modport slave  (input  req_0, req_1, panic_sw,
                  output state_reg, t, sec_t, btn);
endinterface

// File: rtl/door_sequencer.sv
// Door state register plus period timer: IDLE->OPEN->WAIT->CLOSE->IDLE per request,
// with a panic override that only releases on a period boundary.
module door_sequencer #(
  parameter int T            = 8,
  parameter int TIMER_W      = 4,
  parameter int STATE_W      = 3,
  parameter int OPEN_STEPS   = 4,
  parameter int WAIT_PERIODS = 2
) (
  input logic clk,
  input logic rst,
  door_sequencer_if.slave bus
);
  localparam logic [STATE_W-1:0] IDLE  = STATE_W'(0);
  localparam logic [STATE_W-1:0] OPEN  = STATE_W'(1);
  localparam logic [STATE_W-1:0] WAIT  = STATE_W'(2);
  localparam logic [STATE_W-1:0] CLOSE = STATE_W'(3);
  localparam logic [STATE_W-1:0] PANIC = STATE_W'(4);

  localparam logic [TIMER_W-1:0] T_LAST    = TIMER_W'(T);
  localparam logic [STATE_W-1:0] STEP_LAST = STATE_W'(OPEN_STEPS - 1);
  localparam logic [STATE_W-1:0] WAIT_LAST = STATE_W'(WAIT_PERIODS - 1);
  localparam logic [STATE_W-1:0] SEC_MAX   = {STATE_W{1'b1}};

  logic [STATE_W-1:0] state_q, state_d;
  logic [TIMER_W-1:0] t_q, t_d;
  logic [STATE_W-1:0] sec_q, sec_d;
  logic               btn_q, btn_d;
  logic               pe, req_btn, restart;

  assign pe      = (t_q == T_LAST);
  assign req_btn = btn_q ? bus.req_1 : bus.req_0;

  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    restart = 1'b0;
    t_d     = '0;
    sec_d   = '0;

    if (state_q != IDLE) begin
      if (pe) begin
        t_d   = '0;
        sec_d = (state_q == PANIC && sec_q == SEC_MAX) ? sec_q : sec_q + 1'b1;
      end else begin
        t_d   = t_q + 1'b1;
        sec_d = sec_q;
      end
    end

    if (bus.panic_sw && state_q != PANIC) begin
      state_d = PANIC;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_0) begin
            state_d = OPEN;
            btn_d   = 1'b0;
          end else if (bus.req_1) begin
            state_d = OPEN;
            btn_d   = 1'b1;
          end
        end
        OPEN:  if (pe && sec_q == STEP_LAST) state_d = WAIT;
        // Re-request of the selected door beats expiry on the same cycle.
        WAIT: begin
          if (req_btn)                          restart = 1'b1;
          else if (pe && sec_q == WAIT_LAST)    state_d = CLOSE;
        end
        CLOSE: if (pe && sec_q == STEP_LAST) state_d = IDLE;
        PANIC: begin
          if (!bus.panic_sw && pe) begin
            state_d = IDLE;
            btn_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (restart || state_d != state_q) begin
      t_d   = '0;
      sec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      sec_q   <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      sec_q   <= sec_d;
      btn_q   <= btn_d;
    end
  end

  assign bus.state_reg = state_q;
  assign bus.t         = t_q;
  assign bus.sec_t     = sec_q;
  assign bus.btn       = btn_q;
endmodule
